// File: rtl/digota_pkg.sv
// Shared types and constants for the digital-OTA gate-drive stage.
package digota_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    P_ON = 2'd1,
    N_ON = 2'd2,
    DEAD = 2'd3
  } leg_state_t;

  localparam int LEG_CM     = 0;
  localparam int LEG_OM     = 1;
  localparam int LEG_OP     = 2;
  localparam int DEAD_W_DEF = 4;

endpackage

// File: rtl/digota_deadtime_driver_if.sv
// Command/drive bundle between the OTA control logic and the dead-time driver.
interface digota_deadtime_driver_if #(
  parameter int NLEG   = 3,
  parameter int DEAD_W = 4
);
  logic              en;
  logic [DEAD_W-1:0] dead_cyc;
  logic [NLEG-1:0]   gate_p_in;
  logic [NLEG-1:0]   gate_n_in;
  logic              fault_clr;
  logic [NLEG-1:0]   gate_p_out;
  logic [NLEG-1:0]   gate_n_out;
  logic [NLEG-1:0]   fault;
  logic              busy;

  modport master (
    output en, dead_cyc, gate_p_in, gate_n_in, fault_clr,
    input  gate_p_out, gate_n_out, fault, busy
  );

  modport slave (
    input  en, dead_cyc, gate_p_in, gate_n_in, fault_clr,
    output gate_p_out, gate_n_out, fault, busy
  );
endinterface

// File: rtl/digota_deadtime_leg.sv
// One output leg: break-before-make FSM, dead-time counter, sticky fault flag
// and registered gate drives decoded from the next state.
module digota_deadtime_leg
  import digota_pkg::*;
#(
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DEAD_W-1:0] i_dead_cyc,
  input  logic              i_p,
  input  logic              i_n,
  input  logic              i_fault_clr,
  output logic              o_gate_p,
  output logic              o_gate_n,
  output logic              o_fault,
  output logic              o_busy
);
  localparam logic [DEAD_W-1:0] CNT_ONE = DEAD_W'(1);

  leg_state_t        r_state;
  leg_state_t        w_state_nxt;
  logic [DEAD_W-1:0] r_cnt;
  logic [DEAD_W-1:0] w_cnt_nxt;
  logic              r_gate_p;
  logic              r_gate_n;
  logic              r_fault;
  logic              r_busy;

  logic w_want_p;
  logic w_want_n;
  logic w_conflict;

  // p is active-low, n active-high; (0,1) would turn both devices on.
  assign w_want_p   = ~i_p & ~i_n;
  assign w_want_n   =  i_p &  i_n;
  assign w_conflict = ~i_p &  i_n;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      OFF: begin
        if (i_en && w_want_p)      w_state_nxt = P_ON;
        else if (i_en && w_want_n) w_state_nxt = N_ON;
      end
      P_ON: begin
        if (!(i_en && w_want_p)) begin
          w_state_nxt = DEAD;
          w_cnt_nxt   = i_dead_cyc;
        end
      end
      N_ON: begin
        if (!(i_en && w_want_n)) begin
          w_state_nxt = DEAD;
          w_cnt_nxt   = i_dead_cyc;
        end
      end
      DEAD: begin
        // Exit target follows the live request, not the one seen at entry.
        if (r_cnt != '0)           w_cnt_nxt   = r_cnt - CNT_ONE;
        else if (i_en && w_want_p) w_state_nxt = P_ON;
        else if (i_en && w_want_n) w_state_nxt = N_ON;
        else                       w_state_nxt = OFF;
      end
      default: w_state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= OFF;
      r_cnt    <= '0;
      r_gate_p <= 1'b1;
      r_gate_n <= 1'b0;
      r_fault  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gate_p <= ~(w_state_nxt == P_ON);
      r_gate_n <=  (w_state_nxt == N_ON);
      r_fault  <= (w_conflict & i_en) | (r_fault & ~i_fault_clr);
      r_busy   <=  (w_state_nxt == DEAD);
    end
  end

  assign o_gate_p = r_gate_p;
  assign o_gate_n = r_gate_n;
  assign o_fault  = r_fault;
  assign o_busy   = r_busy;
endmodule

// File: rtl/digota_deadtime_driver.sv
// Gate-drive stage: synchronizes the per-leg gate commands and runs one
// dead-time leg per output, so no leg ever drives PMOS and NMOS together.
module digota_deadtime_driver
  import digota_pkg::*;
#(
  parameter int NLEG        = 3,
  parameter int DEAD_W      = DEAD_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  digota_deadtime_driver_if.slave  bus
);
  logic [NLEG-1:0] r_p_sync [SYNC_STAGES];
  logic [NLEG-1:0] r_n_sync [SYNC_STAGES];
  logic [NLEG-1:0] w_gate_p;
  logic [NLEG-1:0] w_gate_n;
  logic [NLEG-1:0] w_fault;
  logic [NLEG-1:0] w_busy;

  // Synchronizers reset to the "want OFF" code (p=1, n=0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_p_sync[s] <= '1;
        r_n_sync[s] <= '0;
      end
    end else begin
      r_p_sync[0] <= bus.gate_p_in;
      r_n_sync[0] <= bus.gate_n_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_p_sync[s] <= r_p_sync[s-1];
        r_n_sync[s] <= r_n_sync[s-1];
      end
    end
  end

  for (genvar g = 0; g < NLEG; g++) begin : g_leg
    digota_deadtime_leg #(
      .DEAD_W (DEAD_W)
    ) u_leg (
      .clk         (clk),
      .rst         (rst),
      .i_en        (bus.en),
      .i_dead_cyc  (bus.dead_cyc),
      .i_p         (r_p_sync[SYNC_STAGES-1][g]),
      .i_n         (r_n_sync[SYNC_STAGES-1][g]),
      .i_fault_clr (bus.fault_clr),
      .o_gate_p    (w_gate_p[g]),
      .o_gate_n    (w_gate_n[g]),
      .o_fault     (w_fault[g]),
      .o_busy      (w_busy[g])
    );
  end

  assign bus.gate_p_out = w_gate_p;
  assign bus.gate_n_out = w_gate_n;
  assign bus.fault      = w_fault;
  assign bus.busy       = |w_busy;
endmodule
